// File: rtl/sonar_ping_ctrl.sv
// Sonar ping sequencer: clear, tx burst, blanking, then echo/timeout capture on the listen window.
// Optional auto-repeat input auto_i is enabled by defining SONAR_PING_AUTO_EN.
module sonar_ping_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [7:0]       half_period_i,
    input  logic [7:0]       n_pulses_i,
    input  logic [CNT_W-1:0] blank_i,
    input  logic [CNT_W-1:0] listen_i,
    input  logic             ce_pcm,
    input  logic             cmp,
    input  logic             irq_clr_i,
`ifdef SONAR_PING_AUTO_EN
    input  logic             auto_i,
`endif
    output logic             tx_o,
    output logic             mclear,
    output logic             busy_o,
    output logic             echo_valid_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] echo_time_o,
    output logic             irq_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StClear  = 3'd1;
    localparam logic [2:0] StBurst  = 3'd2;
    localparam logic [2:0] StBlank  = 3'd3;
    localparam logic [2:0] StListen = 3'd4;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [7:0]       hp_q, hp_d;
    logic [7:0]       phase_q, phase_d;
    logic [8:0]       halves_q, halves_d;
    logic [CNT_W-1:0] blank_q, blank_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;

    logic             tx_d, mclear_d, busy_d, echo_valid_d, timeout_d, irq_d, irq_set;
    logic [CNT_W-1:0] echo_time_d;
    logic [7:0]       hp_eff;
    logic             repeat_en;
    logic [2:0]       done_state;

`ifdef SONAR_PING_AUTO_EN
    assign repeat_en = auto_i;
`else
    assign repeat_en = 1'b0;
`endif

    assign hp_eff     = (half_period_i == 8'd0) ? 8'd1 : half_period_i;
    assign done_state = repeat_en ? StClear : StIdle;

    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        phase_d      = phase_q;
        halves_d     = halves_q;
        blank_d      = blank_q;
        lcnt_d       = lcnt_q;
        tx_d         = 1'b0;
        echo_valid_d = 1'b0;
        timeout_d    = 1'b0;
        echo_time_d  = echo_time_o;
        irq_set      = 1'b0;

        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) state_d = StClear;
                end
                StClear: begin
                    hp_d     = hp_eff;
                    phase_d  = hp_eff - 8'd1;
                    halves_d = {n_pulses_i, 1'b0} - 9'd1;
                    if (n_pulses_i != 8'd0) begin
                        state_d = StBurst;
                        tx_d    = 1'b1;
                    end else if (blank_i == '0) begin
                        state_d = StListen;
                        lcnt_d  = '0;
                    end else begin
                        state_d = StBlank;
                        blank_d = blank_i - CntOne;
                    end
                end
                StBurst: begin
                    if (phase_q != 8'd0) begin
                        phase_d = phase_q - 8'd1;
                        tx_d    = tx_o;
                    end else if (halves_q != 9'd0) begin
                        halves_d = halves_q - 9'd1;
                        phase_d  = hp_q - 8'd1;
                        tx_d     = ~tx_o;
                    end else if (blank_i == '0) begin
                        state_d = StListen;
                        lcnt_d  = '0;
                    end else begin
                        state_d = StBlank;
                        blank_d = blank_i - CntOne;
                    end
                end
                StBlank: begin
                    if (blank_q == '0) begin
                        state_d = StListen;
                        lcnt_d  = '0;
                    end else begin
                        blank_d = blank_q - CntOne;
                    end
                end
                StListen: begin
                    // cmp beats timeout and captures the pre-increment count
                    if (cmp) begin
                        state_d      = done_state;
                        echo_time_d  = lcnt_q;
                        echo_valid_d = 1'b1;
                        irq_set      = 1'b1;
                    end else if (lcnt_q == listen_i) begin
                        state_d     = done_state;
                        echo_time_d = CntMax;
                        timeout_d   = 1'b1;
                        irq_set     = 1'b1;
                    end else if (ce_pcm && (lcnt_q != CntMax)) begin
                        lcnt_d = lcnt_q + CntOne;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        mclear_d = (state_d == StClear) || (state_d == StBlank);
        busy_d   = (state_d != StIdle);
        irq_d    = irq_set | (irq_o & ~irq_clr_i);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            hp_q         <= '0;
            phase_q      <= '0;
            halves_q     <= '0;
            blank_q      <= '0;
            lcnt_q       <= '0;
            tx_o         <= 1'b0;
            mclear       <= 1'b0;
            busy_o       <= 1'b0;
            echo_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            echo_time_o  <= '0;
            irq_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            phase_q      <= phase_d;
            halves_q     <= halves_d;
            blank_q      <= blank_d;
            lcnt_q       <= lcnt_d;
            tx_o         <= tx_d;
            mclear       <= mclear_d;
            busy_o       <= busy_d;
            echo_valid_o <= echo_valid_d;
            timeout_o    <= timeout_d;
            echo_time_o  <= echo_time_d;
            irq_o        <= irq_d;
        end
    end

endmodule

// File: tb/tb_sonar_ping_ctrl.sv
// Self-checking bench for sonar_ping_ctrl: directed scenarios plus randomized pings
// checked against a cycle-offset model of the ping timeline.
module tb_sonar_ping_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i, abort_i, ce_pcm, cmp, irq_clr_i;
    logic [7:0]       half_period_i, n_pulses_i;
    logic [CNT_W-1:0] blank_i, listen_i;
    logic             tx_o, mclear, busy_o, echo_valid_o, timeout_o, irq_o;
    logic [CNT_W-1:0] echo_time_o;
    bit               auto_mode = 1'b0;

    int unsigned      n_checks = 0;
    int unsigned      n_fail = 0;
    logic [CNT_W-1:0] exp_echo_time;
    logic             exp_irq;

    always #5 clk = ~clk;

    sonar_ping_ctrl #(.CNT_W(CNT_W)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .half_period_i (half_period_i),
        .n_pulses_i    (n_pulses_i),
        .blank_i       (blank_i),
        .listen_i      (listen_i),
        .ce_pcm        (ce_pcm),
        .cmp           (cmp),
        .irq_clr_i     (irq_clr_i),
`ifdef SONAR_PING_AUTO_EN
        .auto_i        (auto_mode),
`endif
        .tx_o          (tx_o),
        .mclear        (mclear),
        .busy_o        (busy_o),
        .echo_valid_o  (echo_valid_o),
        .timeout_o     (timeout_o),
        .echo_time_o   (echo_time_o),
        .irq_o         (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx"}, 32'(tx_o), 0);
        check({tag, "_mclear"}, 32'(mclear), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_echo_valid"}, 32'(echo_valid_o), 0);
        check({tag, "_timeout"}, 32'(timeout_o), 0);
        check({tag, "_irq"}, 32'(irq_o), 0);
        check({tag, "_echo_time"}, 32'(echo_time_o), 0);
    endtask

    // One ping from its CLEAR cycle to completion. t counts cycles since CLEAR was entered.
    // cmp_at < 0 means cmp never rises; otherwise cmp is raised once cmp_at ticks have elapsed.
    task automatic run_ping(input int hp, input int np, input int bl, input int ls,
                            input int cmp_at, input bit same_clk, input bit clr_at_end,
                            input bit chained);
        int  hpe, burst_len, t, lcnt;
        bit  ce, cmp_now, done;
        half_period_i = 8'(hp);
        n_pulses_i    = 8'(np);
        blank_i       = CNT_W'(bl);
        listen_i      = CNT_W'(ls);
        if (!chained) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        hpe       = (hp == 0) ? 1 : hp;
        burst_len = 2 * np * hpe;
        lcnt      = 0;
        t         = 0;
        done      = 1'b0;
        while (!done) begin
            if (t > 20000) begin
                check("ping_budget", 0, 1);
                return;
            end
            check("busy", 32'(busy_o), 1);
            if (t > 0) begin
                check("no_pulse", 32'({echo_valid_o, timeout_o}), 0);
                check("irq_hold", 32'(irq_o), 32'(exp_irq));
            end
            if (t == 0) begin
                check("clr_tx", 32'(tx_o), 0);
                check("clr_mclear", 32'(mclear), 1);
            end else if (t <= burst_len) begin
                check("burst_tx", 32'(tx_o), 32'((((t - 1) / hpe) % 2) == 0));
                check("burst_mclear", 32'(mclear), 0);
            end else if (t <= burst_len + bl) begin
                check("blank_tx", 32'(tx_o), 0);
                check("blank_mclear", 32'(mclear), 1);
            end else begin
                check("listen_tx", 32'(tx_o), 0);
                check("listen_mclear", 32'(mclear), 0);
            end
            if (t == 1) begin
                // values sampled in CLEAR must stick for the rest of the burst
                half_period_i = 8'($urandom);
                n_pulses_i    = 8'($urandom);
            end
            if (t > burst_len + bl) begin
                ce      = ($urandom_range(0, 1) == 0);
                cmp_now = (cmp_at >= 0) && (lcnt == cmp_at);
                if (same_clk && cmp_now) ce = 1'b1;
                done      = cmp_now || (lcnt == ls);
                cmp       = cmp_now;
                ce_pcm    = ce;
                irq_clr_i = done && clr_at_end;
                tick();
                cmp       = 1'b0;
                ce_pcm    = 1'b0;
                irq_clr_i = 1'b0;
                if (done) begin
                    exp_echo_time = cmp_now ? CNT_W'(lcnt) : {CNT_W{1'b1}};
                    exp_irq       = 1'b1;
                    check("end_echo_valid", 32'(echo_valid_o), 32'(cmp_now));
                    check("end_timeout", 32'(timeout_o), 32'(!cmp_now));
                    check("end_echo_time", 32'(echo_time_o), 32'(exp_echo_time));
                    check("end_irq", 32'(irq_o), 1);
                    check("end_busy", 32'(busy_o), 32'(auto_mode));
                    check("end_mclear", 32'(mclear), 32'(auto_mode));
                end else if (ce && lcnt < (1 << CNT_W) - 1) begin
                    lcnt++;
                end
            end else begin
                tick();
            end
            t++;
        end
    endtask

    initial begin
        rst = 1'b1;
        {start_i, abort_i, ce_pcm, cmp, irq_clr_i} = '0;
        half_period_i = '0;
        n_pulses_i    = '0;
        blank_i       = '0;
        listen_i      = '0;
        exp_echo_time = '0;
        exp_irq       = 1'b0;
        #12;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // burst 3/2 with blanking, echo after 37 ticks
        run_ping(3, 2, 4, 100, 37, 1'b0, 1'b0, 1'b0);
        tick();
        check("idle_after_echo_pulse", 32'(echo_valid_o), 0);

        // cmp and ce_pcm together at count 5
        run_ping(1, 1, 2, 50, 5, 1'b1, 1'b0, 1'b0);

        // timeout after 4 ticks, then irq clear
        run_ping(2, 1, 0, 4, -1, 1'b0, 1'b0, 1'b0);
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        exp_irq   = 1'b0;
        check("irq_cleared", 32'(irq_o), 0);
        check("echo_time_kept", 32'(echo_time_o), 32'(exp_echo_time));

        // set and clear in the same clock: set wins
        run_ping(0, 1, 1, 3, -1, 1'b0, 1'b1, 1'b0);

        // listen_i=0: immediate timeout, or echo at 0 if cmp present
        run_ping(1, 0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        run_ping(1, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);

        // abort mid-burst
        half_period_i = 8'd3;
        n_pulses_i    = 8'd2;
        blank_i       = 16'd4;
        listen_i      = 16'd20;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        check("pre_abort_busy", 32'(busy_o), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_tx", 32'(tx_o), 0);
        check("abort_mclear", 32'(mclear), 0);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_pulses", 32'({echo_valid_o, timeout_o}), 0);
        check("abort_irq", 32'(irq_o), 32'(exp_irq));
        check("abort_echo_time", 32'(echo_time_o), 32'(exp_echo_time));

        // randomized pings
        for (int i = 0; i < 8; i++) begin
            run_ping(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 26)) - 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // reset mid-burst drops tx without a clock edge
        half_period_i = 8'd5;
        n_pulses_i    = 8'd2;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        check("pre_rst_tx", 32'(tx_o), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_burst");
        #2 rst = 1'b0;
        exp_irq       = 1'b0;
        exp_echo_time = '0;
        tick();

        // n_pulses=0 skips burst; reset mid-blank
        run_ping(2, 1, 0, 2, -1, 1'b0, 1'b0, 1'b0);
        half_period_i = 8'd2;
        n_pulses_i    = 8'd0;
        blank_i       = 16'd10;
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("skip_burst_tx", 32'(tx_o), 0);
        check("skip_burst_mclear", 32'(mclear), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_blank");
        #2 rst = 1'b0;
        exp_irq       = 1'b0;
        exp_echo_time = '0;
        tick();

`ifdef SONAR_PING_AUTO_EN
        // three back-to-back pings, the last one returning to idle
        auto_mode = 1'b1;
        run_ping(2, 1, 1, 6, 3, 1'b0, 1'b0, 1'b0);
        run_ping(1, 2, 0, 5, -1, 1'b0, 1'b0, 1'b1);
        auto_mode = 1'b0;
        run_ping(3, 1, 2, 8, 2, 1'b0, 1'b0, 1'b1);
        tick();
        check("auto_idle", 32'(busy_o), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
